nts_engine_rx_ctrl: RTL and testbench

NTS_ENGINE_RX_CTRL -- requirements
Module: nts_engine_rx_ctrl

---
 rtl/nts_engine_rx_ctrl_if.sv | 27 ++
 rtl/nts_engine_rx_ctrl.sv | 135 +++++++++++++
 tb/tb_nts_engine_rx_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nts_engine_rx_ctrl_if.sv
// Dispatcher-side handshake between the packet dispatch FIFO and the RX control engine.
interface nts_engine_rx_ctrl_if;
  logic        i_dispatch_packet_available;
  logic        i_dispatch_fifo_empty;
  logic        o_dispatch_fifo_rd_en;
  logic [63:0] i_dispatch_fifo_rd_data;
  logic [7:0]  i_dispatch_data_valid;
  logic        o_dispatch_packet_read_discard;

  modport master (
    output i_dispatch_packet_available,
    output i_dispatch_fifo_empty,
    output i_dispatch_fifo_rd_data,
    output i_dispatch_data_valid,
    input  o_dispatch_fifo_rd_en,
    input  o_dispatch_packet_read_discard
  );

  modport slave (
    input  i_dispatch_packet_available,
    input  i_dispatch_fifo_empty,
    input  i_dispatch_fifo_rd_data,
    input  i_dispatch_data_valid,
    output o_dispatch_fifo_rd_en,
    output o_dispatch_packet_read_discard
  );
endinterface

// File: rtl/nts_engine_rx_ctrl.sv
// RX control: copies one dispatched packet into the parser buffer, hands it to the
// parser under a watchdog, drops oversize packets, and keeps saturating statistics.
module nts_engine_rx_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  nts_engine_rx_ctrl_if.slave   dispatch,
  output logic                  o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_mem_wr_addr,
  output logic [63:0]           o_mem_wr_data,
  output logic                  o_process_start,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic [7:0]            o_last_word_valid,
  input  logic                  i_process_done,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_cnt_packets,
  output logic [CNT_WIDTH-1:0]  o_cnt_overflow,
  output logic [CNT_WIDTH-1:0]  o_cnt_timeout
);

  typedef enum logic [1:0] {IDLE, COPY, DRAIN, PROCESS} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [19:0]         WD_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t              state, state_nxt;
  logic                copy_pending;
  logic                buffer_full;
  logic                fifo_rd;
  logic [19:0]         watchdog;
  logic                discard;
  logic                start_set, discard_set;
  logic                pkt_inc, ovf_inc, tmo_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  // A read issued in COPY lands one cycle later, so it already owns a buffer slot.
  assign buffer_full = (o_word_count + (ADDR_WIDTH+1)'(copy_pending)) == DEPTH;

  always_comb begin
    fifo_rd = 1'b0;
    case (state)
      COPY:    fifo_rd = !dispatch.i_dispatch_fifo_empty && !buffer_full;
      DRAIN:   fifo_rd = !dispatch.i_dispatch_fifo_empty;
      default: fifo_rd = 1'b0;
    endcase
  end

  assign dispatch.o_dispatch_fifo_rd_en          = fifo_rd;
  assign dispatch.o_dispatch_packet_read_discard = discard;
  assign o_mem_wr_en   = copy_pending;
  assign o_mem_wr_addr = o_word_count[ADDR_WIDTH-1:0];
  assign o_mem_wr_data = copy_pending ? dispatch.i_dispatch_fifo_rd_data : '0;

  always_comb begin
    state_nxt   = state;
    start_set   = 1'b0;
    discard_set = 1'b0;
    pkt_inc     = 1'b0;
    ovf_inc     = 1'b0;
    tmo_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (dispatch.i_dispatch_packet_available && !dispatch.i_dispatch_fifo_empty)
          state_nxt = COPY;
      end
      COPY: begin
        if (dispatch.i_dispatch_fifo_empty && !copy_pending && o_word_count != '0) begin
          state_nxt = PROCESS;
          start_set = 1'b1;
        end else if (buffer_full && !dispatch.i_dispatch_fifo_empty) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (dispatch.i_dispatch_fifo_empty) begin
          state_nxt   = IDLE;
          discard_set = 1'b1;
          ovf_inc     = 1'b1;
        end
      end
      PROCESS: begin
        // Done is tested first so it wins a tie with the watchdog.
        if (i_process_done) begin
          state_nxt   = IDLE;
          discard_set = 1'b1;
          pkt_inc     = 1'b1;
        end else if (watchdog == WD_LAST) begin
          state_nxt   = IDLE;
          discard_set = 1'b1;
          tmo_inc     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state             <= IDLE;
      copy_pending      <= 1'b0;
      watchdog          <= '0;
      discard           <= 1'b0;
      o_process_start   <= 1'b0;
      o_word_count      <= '0;
      o_last_word_valid <= 8'h00;
      o_busy            <= 1'b0;
      o_cnt_packets     <= '0;
      o_cnt_overflow    <= '0;
      o_cnt_timeout     <= '0;
    end else begin
      state           <= state_nxt;
      o_busy          <= (state_nxt != IDLE);
      o_process_start <= start_set;
      discard         <= discard_set;
      copy_pending    <= fifo_rd && (state == COPY);
      if (state == IDLE && state_nxt == COPY)
        o_word_count <= '0;
      else if (copy_pending)
        o_word_count <= o_word_count + (ADDR_WIDTH+1)'(1);
      if (start_set)
        o_last_word_valid <= dispatch.i_dispatch_data_valid;
      watchdog <= (state == PROCESS) ? watchdog + 20'd1 : '0;
      if (pkt_inc) o_cnt_packets  <= sat_inc(o_cnt_packets);
      if (ovf_inc) o_cnt_overflow <= sat_inc(o_cnt_overflow);
      if (tmo_inc) o_cnt_timeout  <= sat_inc(o_cnt_timeout);
    end
  end

endmodule

// File: tb/tb_nts_engine_rx_ctrl.sv
// Directed bench for nts_engine_rx_ctrl: small buffer, short watchdog and 2-bit counters.
module tb_nts_engine_rx_ctrl;
  localparam int unsigned AW = 3;
  localparam int unsigned TO = 20;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nts_engine_rx_ctrl_if dif();

  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [63:0]   mem_wr_data;
  logic          process_start;
  logic [AW:0]   word_count;
  logic [7:0]    last_word_valid;
  logic          process_done = 1'b0;
  logic          busy;
  logic [CW-1:0] cnt_packets, cnt_overflow, cnt_timeout;

  nts_engine_rx_ctrl #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH     (CW)
  ) dut (
    .i_clk            (clk),
    .i_areset_n       (rst_n),
    .dispatch         (dif.slave),
    .o_mem_wr_en      (mem_wr_en),
    .o_mem_wr_addr    (mem_wr_addr),
    .o_mem_wr_data    (mem_wr_data),
    .o_process_start  (process_start),
    .o_word_count     (word_count),
    .o_last_word_valid(last_word_valid),
    .i_process_done   (process_done),
    .o_busy           (busy),
    .o_cnt_packets    (cnt_packets),
    .o_cnt_overflow   (cnt_overflow),
    .o_cnt_timeout    (cnt_timeout)
  );

  // Dispatch FIFO model: one packet of pkt_len words, data valid the cycle after rd_en.
  int unsigned pkt_len = 0;
  int unsigned rd_ptr  = 0;
  logic [7:0]  pkt_tag = 8'h00;
  logic        load    = 1'b0;

  function automatic logic [63:0] word_of(input logic [7:0] tag, input int unsigned idx);
    return {16'hC0DE, tag, 8'h00, idx};
  endfunction

  assign dif.i_dispatch_fifo_empty = (rd_ptr == pkt_len);

  always @(posedge clk) begin
    if (load)
      rd_ptr <= 0;
    else if (dif.o_dispatch_fifo_rd_en) begin
      dif.i_dispatch_fifo_rd_data <= word_of(pkt_tag, rd_ptr);
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor, sampled on the falling edge.
  int          cyc = 0;
  int          wr_n, rd_n, start_n, disc_n, start_cyc, disc_cyc, empty_cyc;
  logic        disc_busy;
  logic        mon_clr = 1'b0;
  logic [AW-1:0] addr_log [16];
  logic [63:0]   data_log [16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_clr) begin
      wr_n <= 0; rd_n <= 0; start_n <= 0; disc_n <= 0;
      start_cyc <= 0; disc_cyc <= 0; empty_cyc <= -1; disc_busy <= 1'b1;
    end else begin
      if (mem_wr_en) begin
        if (wr_n < 16) begin
          addr_log[wr_n[3:0]] <= mem_wr_addr;
          data_log[wr_n[3:0]] <= mem_wr_data;
        end
        wr_n <= wr_n + 1;
      end
      if (dif.o_dispatch_fifo_rd_en) rd_n <= rd_n + 1;
      if (process_start) begin
        start_n   <= start_n + 1;
        start_cyc <= cyc;
      end
      if (dif.o_dispatch_packet_read_discard) begin
        disc_n    <= disc_n + 1;
        disc_cyc  <= cyc;
        disc_busy <= busy;
      end
      if (busy && dif.i_dispatch_fifo_empty && empty_cyc < 0) empty_cyc <= cyc;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_packet(input int unsigned n, input logic [7:0] mask, input logic [7:0] tag);
    clear_mon();
    pkt_tag = tag;
    load = 1'b1;
    tick();
    load = 1'b0;
    pkt_len = n;
    dif.i_dispatch_data_valid = mask;
    dif.i_dispatch_packet_available = 1'b1;
    tick();
    dif.i_dispatch_packet_available = 1'b0;
  endtask

  task automatic wait_start(input int max);
    for (int i = 0; i < max && start_n == 0; i++) tick();
    check("start_seen", 64'(start_n != 0), 1);
  endtask

  task automatic wait_disc(input int max);
    for (int i = 0; i < max && disc_n == 0; i++) tick();
    check("discard_seen", 64'(disc_n != 0), 1);
  endtask

  task automatic goto_cycle(input int target);
    while (cyc < target) tick();
  endtask

  task automatic normal_packet(input int unsigned n, input logic [7:0] mask, input logic [7:0] tag);
    run_packet(n, mask, tag);
    wait_start(40);
    goto_cycle(start_cyc + 10);
    process_done = 1'b1;
    tick();
    process_done = 1'b0;
    wait_disc(40);
    tick();
  endtask

  initial begin
    dif.i_dispatch_packet_available = 1'b0;
    dif.i_dispatch_data_valid = 8'h00;
    dif.i_dispatch_fifo_rd_data = '0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 0);
    check("rst_rd_en", 64'(dif.o_dispatch_fifo_rd_en), 0);
    check("rst_word_count", 64'(word_count), 0);
    check("rst_last_valid", 64'(last_word_valid), 0);
    check("rst_counters", 64'({cnt_packets, cnt_overflow, cnt_timeout}), 0);
    rst_n = 1'b1;
    tick();

    // Normal 6-word packet, done 10 cycles after start.
    normal_packet(6, 8'h0F, 8'h01);
    check("norm_writes", 64'(wr_n), 6);
    check("norm_reads", 64'(rd_n), 6);
    for (int i = 0; i < 6; i++) begin
      check("norm_addr", 64'(addr_log[i]), 64'(i));
      check("norm_data", data_log[i], word_of(8'h01, i));
    end
    check("norm_word_count", 64'(word_count), 6);
    check("norm_last_valid", 64'(last_word_valid), 64'h0F);
    check("norm_starts", 64'(start_n), 1);
    check("norm_discards", 64'(disc_n), 1);
    check("norm_busy_at_discard", 64'(disc_busy), 0);
    check("norm_latency_le2", 64'((start_cyc - empty_cyc) <= 2 && empty_cyc >= 0), 1);
    check("norm_cnt_packets", 64'(cnt_packets), 1);
    check("norm_busy", 64'(busy), 0);

    // Watchdog timeout; done pulsed only while IDLE/COPY must be ignored.
    do_reset();
    process_done = 1'b1;
    run_packet(3, 8'hFF, 8'h02);
    tick();
    process_done = 1'b0;
    wait_start(40);
    wait_disc(60);
    check("tmo_delay", 64'(disc_cyc - start_cyc), 20);
    check("tmo_cnt_timeout", 64'(cnt_timeout), 1);
    check("tmo_cnt_packets", 64'(cnt_packets), 0);
    check("tmo_last_valid", 64'(last_word_valid), 64'hFF);

    // Done in the very cycle the watchdog expires.
    do_reset();
    run_packet(2, 8'h01, 8'h03);
    wait_start(40);
    goto_cycle(start_cyc + 19);
    process_done = 1'b1;
    tick();
    process_done = 1'b0;
    wait_disc(40);
    check("race_delay", 64'(disc_cyc - start_cyc), 20);
    check("race_cnt_packets", 64'(cnt_packets), 1);
    check("race_cnt_timeout", 64'(cnt_timeout), 0);

    // Overflow: 12 words into an 8-word buffer.
    do_reset();
    run_packet(12, 8'h3F, 8'h04);
    wait_disc(80);
    tick();
    check("ovf_writes", 64'(wr_n), 8);
    check("ovf_reads", 64'(rd_n), 12);
    check("ovf_last_addr", 64'(addr_log[7]), 7);
    check("ovf_last_data", data_log[7], word_of(8'h04, 7));
    check("ovf_starts", 64'(start_n), 0);
    check("ovf_discards", 64'(disc_n), 1);
    check("ovf_cnt_overflow", 64'(cnt_overflow), 1);
    check("ovf_cnt_packets", 64'(cnt_packets), 0);
    check("ovf_busy", 64'(busy), 0);

    // Saturation of the 2-bit packet counter.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      normal_packet(2, 8'h80 + 8'(k), 8'h10 + 8'(k));
      check("sat_cnt_packets", 64'(cnt_packets), (k < 3) ? 64'(k + 1) : 64'd3);
    end
    check("sat_last_valid", 64'(last_word_valid), 64'h84);

    // Reset in the middle of a copy.
    run_packet(6, 8'h0F, 8'h06);
    for (int i = 0; i < 40 && wr_n < 3; i++) tick();
    check("mid_writes_before_reset", 64'(wr_n), 3);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 64'(busy), 0);
    check("mid_rd_en", 64'(dif.o_dispatch_fifo_rd_en), 0);
    check("mid_wr_en", 64'(mem_wr_en), 0);
    check("mid_wr_addr_data", {mem_wr_data[63:AW], mem_wr_data[AW-1:0] | mem_wr_addr}, 0);
    check("mid_word_count", 64'(word_count), 0);
    check("mid_pulses", 64'({process_start, dif.o_dispatch_packet_read_discard}), 0);
    check("mid_last_valid", 64'(last_word_valid), 0);
    check("mid_counters", 64'({cnt_packets, cnt_overflow, cnt_timeout}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    normal_packet(6, 8'h0F, 8'h07);
    check("fresh_writes", 64'(wr_n), 6);
    check("fresh_first_addr", 64'(addr_log[0]), 0);
    check("fresh_first_data", data_log[0], word_of(8'h07, 0));
    check("fresh_cnt_packets", 64'(cnt_packets), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
